// File: rtl/csr_stream_encoder.sv
// Dense row-major NxN activation map to CSR: one {col,data} write per nonzero plus a per-row index pointer.
// Latency: store/pointer/done registered one cycle after the accepted element; done one cycle after start when N=0.
// Backpressure: in_ready is high only while a map is running; in_valid gaps simply stall the row/col counters.
module csr_stream_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int MAX_ROWS   = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [IDX_WIDTH-1:0]              row_size,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              store,
    output logic [IDX_WIDTH-1:0]              nz_col,
    output logic [DATA_WIDTH-1:0]             nz_data,
    output logic [CNT_WIDTH*(MAX_ROWS+1)-1:0] index_pointer,
    output logic [CNT_WIDTH-1:0]              nz_total,
    output logic                              busy,
    output logic                              done
);

    localparam int                   PTR_W   = CNT_WIDTH * (MAX_ROWS + 1);
    localparam logic [IDX_WIDTH-1:0] MAX_N   = IDX_WIDTH'(MAX_ROWS);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] n_lat;
    logic [IDX_WIDTH-1:0] col_cnt;
    logic [IDX_WIDTH-1:0] row_cnt;
    logic [CNT_WIDTH-1:0] ptr [MAX_ROWS+1];

    logic                 accept;
    logic                 is_nz;
    logic                 col_last;
    logic                 row_last;
    logic [IDX_WIDTH-1:0] n_clamped;
    logic [CNT_WIDTH-1:0] total_nxt;

    always_comb begin
        accept    = in_valid && in_ready;
        is_nz     = (in_data != '0);
        col_last  = (col_cnt == n_lat - IDX_ONE);
        row_last  = (row_cnt == n_lat - IDX_ONE);
        n_clamped = (row_size > MAX_N) ? MAX_N : row_size;
        total_nxt = nz_total + (is_nz ? CNT_ONE : '0);
    end

    // Entry 0 sits in the most significant slot so the pointer reads left to right.
    always_comb begin
        index_pointer = '0;
        for (int k = 0; k <= MAX_ROWS; k++) begin
            index_pointer[PTR_W-1-CNT_WIDTH*k -: CNT_WIDTH] = ptr[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            store    <= 1'b0;
            nz_col   <= '0;
            nz_data  <= '0;
            nz_total <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int k = 0; k <= MAX_ROWS; k++) begin
                ptr[k] <= '0;
            end
        end else begin
            store <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat    <= n_clamped;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        nz_total <= '0;
                        busy     <= 1'b1;
                        for (int k = 0; k <= MAX_ROWS; k++) begin
                            ptr[k] <= '0;
                        end
                        // An empty map completes without ever opening the input.
                        if (n_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (is_nz) begin
                            store   <= 1'b1;
                            nz_col  <= col_cnt;
                            nz_data <= in_data;
                        end
                        nz_total <= total_nxt;
                        if (col_last) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + IDX_ONE;
                            // Closing row r publishes the running count as entry r+1.
                            for (int k = 1; k <= MAX_ROWS; k++) begin
                                if (row_cnt == IDX_WIDTH'(k - 1)) begin
                                    ptr[k] <= total_nxt;
                                end
                            end
                            if (row_last) begin
                                state    <= S_DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + IDX_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_stream_encoder.sv
// Bench for csr_stream_encoder: an element-count model (col = k mod N, row = k div N) predicts every output
// each cycle, with literal checks pinning the directed maps.
module tb_csr_stream_encoder;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int CW = 8;
    localparam int MR = 6;
    localparam int PW = CW * (MR + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] row_size;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          store;
    logic [IW-1:0] nz_col;
    logic [DW-1:0] nz_data;
    logic [PW-1:0] index_pointer;
    logic [CW-1:0] nz_total;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    csr_stream_encoder #(
        .DATA_WIDTH(DW),
        .IDX_WIDTH (IW),
        .CNT_WIDTH (CW),
        .MAX_ROWS  (MR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .row_size     (row_size),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .store        (store),
        .nz_col       (nz_col),
        .nz_data      (nz_data),
        .index_pointer(index_pointer),
        .nz_total     (nz_total),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state: map size, accepted element count, expected outputs.
    bit chk_en = 1'b0;
    bit m_run  = 1'b0;
    bit m_fin  = 1'b0;
    int m_n    = 0;
    int m_k    = 0;
    int e_ptr[MR+1];
    int e_total = 0;
    int e_col   = 0;
    int e_data  = 0;
    bit e_store = 1'b0;
    bit e_done  = 1'b0;
    bit e_busy  = 1'b0;
    bit e_ready = 1'b0;

    int seen[$];
    int done_cnt = 0;

    function automatic logic [PW-1:0] pack_ptr();
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k <= MR; k++) begin
            p[PW-1-CW*k -: CW] = CW'(e_ptr[k]);
        end
        return p;
    endfunction

    always @(posedge clk) begin
        int col;
        int row;
        e_store = 1'b0;
        e_done  = 1'b0;
        if (reset) begin
            chk_en  = 1'b1;
            m_run   = 1'b0;
            m_fin   = 1'b0;
            m_n     = 0;
            m_k     = 0;
            e_total = 0;
            e_col   = 0;
            e_data  = 0;
            e_busy  = 1'b0;
            e_ready = 1'b0;
            for (int k = 0; k <= MR; k++) e_ptr[k] = 0;
        end else if (m_fin) begin
            m_fin  = 1'b0;
            e_busy = 1'b0;
        end else if (m_run) begin
            if (in_valid) begin
                col = m_k % m_n;
                row = m_k / m_n;
                if (in_data != 0) begin
                    e_store = 1'b1;
                    e_col   = col;
                    e_data  = int'(in_data);
                    e_total++;
                end
                m_k++;
                if (col == m_n - 1) e_ptr[row + 1] = e_total;
                if (m_k == m_n * m_n) begin
                    m_run   = 1'b0;
                    m_fin   = 1'b1;
                    e_done  = 1'b1;
                    e_ready = 1'b0;
                end
            end
        end else if (start) begin
            m_n     = (int'(row_size) > MR) ? MR : int'(row_size);
            m_k     = 0;
            e_total = 0;
            e_busy  = 1'b1;
            for (int k = 0; k <= MR; k++) e_ptr[k] = 0;
            if (m_n == 0) begin
                m_fin  = 1'b1;
                e_done = 1'b1;
            end else begin
                m_run   = 1'b1;
                e_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", longint'(in_ready), longint'(e_ready));
            chk("busy", longint'(busy), longint'(e_busy));
            chk("done", longint'(done), longint'(e_done));
            chk("store", longint'(store), longint'(e_store));
            chk("nz_col", longint'(nz_col), longint'(e_col));
            chk("nz_data", longint'(nz_data), longint'(e_data));
            chk("nz_total", longint'(nz_total), longint'(e_total));
            chk("index_pointer", longint'(index_pointer), longint'(pack_ptr()));
            if (store) seen.push_back(int'(nz_col) * 256 + int'(nz_data));
            if (done) done_cnt++;
        end
    end

    // Feeds vals after a start pulse; gap 0 = always valid, 1 = alternate cycles, 2 = random.
    // stop_after >= 0 ends feeding early; restart_at >= 0 raises start while that element is offered.
    task automatic run_map(input int rs, input int vals[$], input int gap, input int stop_after,
                           input int restart_at);
        int idx;
        int target;
        int budget;
        bit v;
        bit acc;
        bit tog;
        seen.delete();
        done_cnt = 0;
        start    = 1'b1;
        row_size = IW'(rs);
        @(posedge clk);
        #1;
        start  = 1'b0;
        idx    = 0;
        budget = 500;
        tog    = 1'b0;
        target = (stop_after >= 0) ? stop_after : vals.size();
        while (idx < target && budget > 0) begin
            budget--;
            tog = ~tog;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'(($urandom_range(0, 2) != 0));
            in_valid = v;
            in_data  = v ? DW'(vals[idx]) : DW'($urandom_range(0, 255));
            start    = (restart_at >= 0 && idx == restart_at);
            if (start) row_size = IW'(5);
            acc = v && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < target) chk("feed_budget", longint'(idx), longint'(target));
        if (stop_after < 0) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_t2(input string tag);
        logic [PW-1:0] exp_ptr;
        exp_ptr = {8'd0, 8'd1, 8'd2, 32'd0};
        chk({tag, "_model_ptr"}, longint'(pack_ptr()), longint'(exp_ptr));
        chk({tag, "_ptr"}, longint'(index_pointer), longint'(exp_ptr));
        chk({tag, "_total"}, longint'(nz_total), 2);
        chk({tag, "_nstores"}, seen.size(), 2);
        if (seen.size() == 2) begin
            chk({tag, "_store0"}, seen[0], 16'h0005);
            chk({tag, "_store1"}, seen[1], 16'h0107);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t2[$];
        int z9[$];
        int q36[$];
        int rq[$];
        int rs;
        int ne;
        logic [PW-1:0] exp5;

        reset    = 1'b1;
        start    = 1'b0;
        row_size = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Test 1: reset mid-idle with start and in_valid asserted alongside it.
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        row_size = IW'(2);
        in_data  = 8'h33;
        @(posedge clk);
        #1;
        chk("t1_busy", longint'(busy), 0);
        chk("t1_in_ready", longint'(in_ready), 0);
        chk("t1_ptr", longint'(index_pointer), 0);
        chk("t1_total", longint'(nz_total), 0);
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_still_idle", longint'(busy), 0);

        // Test 2: N=2, 5,0,0,7.
        t2 = '{5, 0, 0, 7};
        run_map(2, t2, 0, -1, -1);
        check_t2("t2");

        // Test 3: N=3, all zeros.
        z9 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_map(3, z9, 0, -1, -1);
        chk("t3_nstores", seen.size(), 0);
        chk("t3_ptr", longint'(index_pointer), 0);
        chk("t3_done_cnt", done_cnt, 1);

        // Test 4: same map as test 2 with alternating in_valid.
        run_map(2, t2, 1, -1, -1);
        check_t2("t4");

        // Test 5: oversize row_size clamps to 6.
        for (int i = 1; i <= 36; i++) q36.push_back(i);
        run_map(9, q36, 0, -1, -1);
        exp5 = {8'd0, 8'd6, 8'd12, 8'd18, 8'd24, 8'd30, 8'd36};
        chk("t5_ptr", longint'(index_pointer), longint'(exp5));
        chk("t5_total", longint'(nz_total), 36);
        chk("t5_nstores", seen.size(), 36);
        if (seen.size() == 36) begin
            chk("t5_store6", seen[6], 16'h0007);
            chk("t5_store35", seen[35], 16'h0524);
        end

        // Test 6: reset mid-map, then a run with an ignored restart.
        run_map(2, t2, 0, 3, -1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_ptr_cleared", longint'(index_pointer), 0);
        chk("t6_idle", longint'(busy), 0);
        run_map(2, t2, 0, -1, 1);
        check_t2("t6");

        // Empty map.
        run_map(0, rq, 0, -1, -1);
        chk("n0_done_cnt", done_cnt, 1);
        chk("n0_ptr", longint'(index_pointer), 0);

        // Randomized maps against the model.
        for (int m = 0; m < 10; m++) begin
            rs = $urandom_range(0, 9);
            ne = (rs > MR) ? MR : rs;
            rq.delete();
            for (int i = 0; i < ne * ne; i++) begin
                rq.push_back(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 255)) : 0);
            end
            run_map(rs, rq, 2, -1, -1);
            chk("rand_done_cnt", done_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
